// File: rtl/spi_flash_pkg.sv
// Shared types and constants for the SPI flash execute-in-place read port.
`timescale 1ns/1ps
package spi_flash_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    RESP
  } state_t;

  localparam logic [7:0] CMD_READ      = 8'h03;
  localparam int         CMD_ADDR_BITS = 32;
  localparam int         DATA_BITS     = 32;
  localparam int         SCK_PERIODS   = CMD_ADDR_BITS + DATA_BITS;

  // Flash returns bytes in address order; the bus wants the first byte in [7:0].
  function automatic logic [DATA_BITS-1:0] byte_swap(input logic [DATA_BITS-1:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// SPI mode-0 clock divider: sck idles low, toggles every DIV cycles while
// enabled, and flags the cycle before each rising/falling transition.
`timescale 1ns/1ps
module spi_sck_gen #(
  parameter int unsigned DIV = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  output logic sck,
  output logic rise,
  output logic fall
);

  logic [7:0] cnt;
  logic       tick;

  assign tick = en && (cnt == 8'(DIV - 1));
  assign rise = tick && !sck;
  assign fall = tick && sck;

  // Half-period counter and sck register; dropping en parks sck low.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // in the design samples pre-edge values, independent of block ordering.
    if (reset || !en) begin
      cnt <= '0;
      sck <= 1'b0;
    end else if (tick) begin
      cnt <= '0;
      sck <= !sck;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/spi_flash_xip.sv
// Word-read port onto an SPI NOR flash: sends READ (0x03) plus a 24-bit
// address, then clocks in 32 data bits and presents them little-endian.
`timescale 1ns/1ps
module spi_flash_xip
  import spi_flash_pkg::*;
#(
  parameter int unsigned DIV = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [23:0]          req_addr,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [DATA_BITS-1:0] resp_data,
  output logic                 sck,
  output logic                 ss,
  output logic                 mosi,
  input  logic                 miso
);

  state_t                     state, state_next;
  logic [7:0]                 cyc;      // SETUP dwell counter
  logic [6:0]                 periods;  // completed sck periods (falling edges)
  logic [8:0]                 gap;      // consecutive cycles with ss high
  logic [CMD_ADDR_BITS-1:0]   tx;
  logic [DATA_BITS-1:0]       rx;
  logic                       shifting, sck_rise, sck_fall, accept;
  logic                       unused_addr_bits;

  // Reads are word aligned, so the byte-lane bits carry no information.
  assign unused_addr_bits = ^req_addr[1:0];

  // The divider stops as soon as the 64th falling edge has gone out.
  assign shifting = (state == SHIFT) && (periods != 7'(SCK_PERIODS));
  assign accept   = req_valid && req_ready;

  spi_sck_gen #(.DIV(DIV)) u_sck_gen (
    .clock (clock),
    .reset (reset),
    .en    (shifting),
    .sck   (sck),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  // Next-state and handshake decode.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_next = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = (gap >= 9'(2 * DIV));
        if (req_valid && req_ready) state_next = SETUP;
      end
      SETUP: if (cyc == 8'(DIV - 1)) state_next = SHIFT;
      SHIFT: if (periods == 7'(SCK_PERIODS)) state_next = RESP;
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Control registers: state, chip select, mosi, counters and the response.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      ss        <= 1'b1;
      mosi      <= 1'b0;
      gap       <= '0;
      cyc       <= '0;
      periods   <= '0;
      resp_data <= '0;
    end else begin
      state <= state_next;
      ss    <= (state_next == IDLE) || (state_next == RESP);
      if (!ss)              gap <= '0;
      else if (gap != '1)   gap <= gap + 9'd1;
      cyc <= (state == SETUP) ? cyc + 8'd1 : '0;
      if (state != SHIFT)   periods <= '0;
      else if (sck_fall)    periods <= periods + 7'd1;
      // Bit 31 is presented on entry to SHIFT; later bits move only as sck falls.
      if (state == SETUP && state_next == SHIFT) mosi <= tx[CMD_ADDR_BITS-1];
      else if (sck_fall)                         mosi <= tx[CMD_ADDR_BITS-2];
      else if (state != SHIFT)                   mosi <= 1'b0;
      if (state == SHIFT && state_next == RESP)  resp_data <= byte_swap(rx);
    end
  end

  // Shift registers: command out (zero-filled, so mosi idles after 32 bits)
  // and data in on rising edges 33..64.
  always_ff @(posedge clock) begin
    // NOTE: pure datapath, no reset: tx is loaded on every accept and rx is
    // fully overwritten before it is ever used.
    if (accept)        tx <= {CMD_READ, req_addr[23:2], 2'b00};
    else if (sck_fall) tx <= tx << 1;
    if (sck_rise && periods >= 7'(CMD_ADDR_BITS)) rx <= {rx[DATA_BITS-2:0], miso};
  end

endmodule

// File: tb/tb_spi_flash_xip.sv
// Bench for spi_flash_xip: three instances (DIV = 1, 3, 2), each with a
// behavioural mode-0 flash that decodes the command and returns bytes.
`timescale 1ns/1ps
module tb_spi_flash_xip;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid   [3];
  logic [23:0] req_addr    [3];
  logic        resp_ready  [3];
  logic        req_ready_a [3];
  logic        resp_valid_a[3];
  logic [31:0] resp_data_a [3];
  logic        sck_a       [3];
  logic        ss_a        [3];
  logic        mosi_a      [3];
  logic [31:0] cmd_last    [3];
  int          mosi_nz     [3];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    case (a)
      24'h000000: return 8'hEF;
      24'h000001: return 8'hBE;
      24'h000002: return 8'hAD;
      24'h000003: return 8'hDE;
      24'h000004: return 8'h78;
      24'h000005: return 8'h56;
      24'h000006: return 8'h34;
      24'h000007: return 8'h12;
      24'h000100: return 8'h11;
      24'h000101: return 8'h22;
      24'h000102: return 8'h33;
      24'h000103: return 8'h44;
      default:    return 8'hA5;
    endcase
  endfunction

  genvar gi;
  for (gi = 0; gi < 3; gi++) begin : g_dut
    localparam int unsigned D = (gi == 0) ? 1 : (gi == 1) ? 3 : 2;
    logic        sck_w, ss_w, mosi_w, rr_w, rv_w;
    logic [31:0] rd_w;
    logic        miso_q   = 1'b0;
    logic        sck_prev = 1'b0;
    logic        ss_prev  = 1'b1;
    int          rc = 0, fc = 0, nz = 0;
    logic [31:0] cmd_q = '0, stream = '0;

    spi_flash_xip #(.DIV(D)) u_dut (
      .clock      (clock),
      .reset      (reset),
      .req_valid  (req_valid[gi]),
      .req_ready  (rr_w),
      .req_addr   (req_addr[gi]),
      .resp_valid (rv_w),
      .resp_ready (resp_ready[gi]),
      .resp_data  (rd_w),
      .sck        (sck_w),
      .ss         (ss_w),
      .mosi       (mosi_w),
      .miso       (miso_q)
    );

    assign req_ready_a[gi]  = rr_w;
    assign resp_valid_a[gi] = rv_w;
    assign resp_data_a[gi]  = rd_w;
    assign sck_a[gi]        = sck_w;
    assign ss_a[gi]         = ss_w;
    assign mosi_a[gi]       = mosi_w;
    assign cmd_last[gi]     = cmd_q;
    assign mosi_nz[gi]      = nz;

    // Flash model: command in on rises 1..32, data out on falls 32..63.
    always @(sck_w or ss_w) begin
      if (ss_prev && !ss_w) begin
        rc = 0;
        fc = 0;
      end
      if (!ss_w) begin
        if (!sck_prev && sck_w) begin
          if (rc < 32) cmd_q = {cmd_q[30:0], mosi_w};
          else if (mosi_w !== 1'b0) nz++;
          rc++;
        end
        if (sck_prev && !sck_w) begin
          fc++;
          if (fc == 32)
            stream = {flash_byte(cmd_q[23:0]), flash_byte(cmd_q[23:0] + 24'd1),
                      flash_byte(cmd_q[23:0] + 24'd2), flash_byte(cmd_q[23:0] + 24'd3)};
          if (fc >= 32 && fc < 64) miso_q = stream[63 - fc];
          else miso_q = 1'b0;
        end
      end
      sck_prev = sck_w;
      ss_prev  = ss_w;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One read on instance g; optionally holds resp_ready low for `hold` cycles.
  task automatic do_read(input int g, input int d, input logic [23:0] addr,
                         input logic [31:0] exp_cmd, input logic [31:0] exp_data,
                         input int exp_lat, input int hold);
    int n = 0, lat = 0, rises = 0, run = 0, bad_hi = 0, bad_lo = 0, bad_hold = 0;
    int nz0 = mosi_nz[g];
    logic acc = 1'b0, prev;
    logic [31:0] held;
    req_addr[g]  = addr;
    req_valid[g] = 1'b1;
    while (!acc && n < 1000) begin
      acc = req_ready_a[g];
      tick();
      n++;
    end
    check($sformatf("dut%0d_accept", g), acc, 1);
    req_valid[g] = 1'b0;
    req_addr[g]  = 24'hFFFFFF;
    check($sformatf("dut%0d_ss_low_after_accept", g), ss_a[g], 0);
    prev = sck_a[g];
    while (!resp_valid_a[g] && lat < 2000) begin
      tick();
      lat++;
      if (sck_a[g] != prev) begin
        if (prev && run != d) bad_hi++;
        if (!prev && rises > 0 && run != d) bad_lo++;
        if (!prev) rises++;
        prev = sck_a[g];
        run = 1;
      end else run++;
    end
    check($sformatf("dut%0d_resp_latency", g), lat, exp_lat);
    check($sformatf("dut%0d_sck_periods", g), rises, 64);
    check($sformatf("dut%0d_sck_high_bad", g), bad_hi, 0);
    check($sformatf("dut%0d_sck_low_bad", g), bad_lo, 0);
    check($sformatf("dut%0d_cmd_word", g), cmd_last[g], exp_cmd);
    check($sformatf("dut%0d_mosi_nonzero_in_data", g), mosi_nz[g] - nz0, 0);
    check($sformatf("dut%0d_resp_data", g), resp_data_a[g], exp_data);
    check($sformatf("dut%0d_ss_high_in_resp", g), ss_a[g], 1);
    held = resp_data_a[g];
    for (int i = 0; i < hold; i++) begin
      tick();
      if (!resp_valid_a[g] || resp_data_a[g] !== held || req_ready_a[g] ||
          !ss_a[g] || sck_a[g]) bad_hold++;
    end
    if (hold > 0) check($sformatf("dut%0d_hold_stable_bad", g), bad_hold, 0);
    resp_ready[g] = 1'b1;
    tick();
    resp_ready[g] = 1'b0;
    check($sformatf("dut%0d_resp_valid_dropped", g), resp_valid_a[g], 0);
  endtask

  // Reset asserted right after the 20th sck rise on instance 0.
  task automatic abort_read();
    int n = 0, rises = 0, seen = 0;
    logic acc = 1'b0, prev;
    req_addr[0]  = 24'h000004;
    req_valid[0] = 1'b1;
    while (!acc && n < 1000) begin
      acc = req_ready_a[0];
      tick();
      n++;
    end
    check("abort_accept", acc, 1);
    req_valid[0] = 1'b0;
    prev = sck_a[0];
    n = 0;
    while (rises < 20 && n < 500) begin
      tick();
      n++;
      if (sck_a[0] && !prev) rises++;
      prev = sck_a[0];
    end
    check("abort_reached_rise20", rises, 20);
    reset = 1'b1;
    tick();
    check("abort_ss_high", ss_a[0], 1);
    check("abort_sck_low", sck_a[0], 0);
    reset = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (resp_valid_a[0]) seen++;
    end
    check("abort_no_resp", seen, 0);
  endtask

  // Two reads on instance 2 with req_valid and resp_ready held high.
  task automatic back_to_back();
    int nacc = 0, nresp = 0, run = 0, gap = -1;
    logic acc, got;
    logic [31:0] d, cl;
    logic [31:0] rdat[2], rcmd[2];
    rdat[0] = '0; rdat[1] = '0; rcmd[0] = '0; rcmd[1] = '0;
    req_addr[2]   = 24'h000000;
    req_valid[2]  = 1'b1;
    resp_ready[2] = 1'b1;
    for (int c = 0; c < 3000 && nresp < 2; c++) begin
      acc = req_valid[2] && req_ready_a[2];
      got = resp_valid_a[2];
      d   = resp_data_a[2];
      cl  = cmd_last[2];
      tick();
      if (got) begin
        rdat[nresp] = d;
        rcmd[nresp] = cl;
        nresp++;
      end
      if (acc) begin
        nacc++;
        if (nacc == 1) req_addr[2] = 24'h000100;
        else req_valid[2] = 1'b0;
      end
      if (ss_a[2]) run++;
      else begin
        if (nacc == 2 && gap < 0) gap = run;
        run = 0;
      end
    end
    req_valid[2]  = 1'b0;
    resp_ready[2] = 1'b0;
    check("b2b_resp_count", nresp, 2);
    check("b2b_data0", rdat[0], 32'hDEADBEEF);
    check("b2b_data1", rdat[1], 32'h44332211);
    check("b2b_cmd0", rcmd[0], 32'h03000000);
    check("b2b_cmd1", rcmd[1], 32'h03000100);
    check("b2b_ss_gap_ge_4", gap >= 4, 1);
  endtask

  initial begin
    int first[3];
    int exp_first[3];
    exp_first[0] = 2; exp_first[1] = 6; exp_first[2] = 4;
    for (int g = 0; g < 3; g++) begin
      req_valid[g]  = 1'b0;
      req_addr[g]   = '0;
      resp_ready[g] = 1'b0;
      first[g]      = 0;
    end
    reset = 1'b1;
    repeat (3) tick();
    for (int g = 0; g < 3; g++) begin
      check($sformatf("dut%0d_rst_sck", g), sck_a[g], 0);
      check($sformatf("dut%0d_rst_ss", g), ss_a[g], 1);
      check($sformatf("dut%0d_rst_mosi", g), mosi_a[g], 0);
      check($sformatf("dut%0d_rst_req_ready", g), req_ready_a[g], 0);
      check($sformatf("dut%0d_rst_resp_valid", g), resp_valid_a[g], 0);
      check($sformatf("dut%0d_rst_resp_data", g), resp_data_a[g], 0);
    end
    reset = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      for (int g = 0; g < 3; g++)
        if (first[g] == 0 && req_ready_a[g]) first[g] = n;
    end
    for (int g = 0; g < 3; g++)
      check($sformatf("dut%0d_first_ready_cycle", g), first[g], exp_first[g]);

    do_read(0, 1, 24'h000007, 32'h03000004, 32'h12345678, 130, 0);
    do_read(1, 3, 24'h000007, 32'h03000004, 32'h12345678, 388, 0);
    do_read(0, 1, 24'h000004, 32'h03000004, 32'h12345678, 130, 10);
    abort_read();
    do_read(0, 1, 24'h000007, 32'h03000004, 32'h12345678, 130, 0);
    back_to_back();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_flash_xip.md
SPI_FLASH_XIP -- requirements
Module: spi_flash_xip

Interface
REQ-001 SHALL have parameter DIV, default 1: sck half-period in clock cycles, legal range 1..255.
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  1  read request present.
REQ-005 SHALL have port req_ready  output  1  request accepted when req_valid && req_ready at a rising edge.
REQ-006 SHALL have port req_addr  input  24  byte address; bits [1:0] ignored, word-aligned read.
REQ-007 SHALL have port resp_valid  output  1  read data available.
REQ-008 SHALL have port resp_ready  input  1  consumer takes data when resp_valid && resp_ready.
REQ-009 SHALL have port resp_data  output  32  little-endian word: first flash byte in [7:0].
REQ-010 SHALL have ports sck (output 1, SPI clock, idle low), ss (output 1, active-low select, idle high), mosi (output 1), miso (input 1).

Function
REQ-011 SHALL implement states IDLE, SETUP, SHIFT, RESP; IDLE->SETUP on accept, SETUP->SHIFT after DIV cycles, SHIFT->RESP after 64th sck falling edge, RESP->IDLE on resp handshake.
REQ-012 SHALL assert req_ready only in IDLE and only after ss has been high for at least 2*DIV consecutive cycles; with resp pending req_ready SHALL be 0.
REQ-013 SHALL capture req_addr on accept; later changes on req_addr SHALL have no effect.
REQ-014 SHALL drive ss low from the cycle after accept through the last sck falling edge, and high in the cycle RESP is entered.
REQ-015 In SHIFT SHALL generate 64 sck periods, each DIV cycles high then DIV cycles low (SPI mode 0).
REQ-016 SHALL shift out, MSB first, the 32-bit word {8'h03, req_addr[23:2], 2'b00}; bit 31 SHALL be on mosi on entry to SHIFT; mosi SHALL change only in the cycle sck falls; mosi SHALL be 0 during the last 32 periods and outside SHIFT.
REQ-017 SHALL sample miso in the cycle sck rises (pre-edge value) on rising edges 33..64 only, shifting into a 32-bit register MSB first.
REQ-018 SHALL set resp_data = {b3,b2,b1,b0} where b0 is the first received byte; resp_data SHALL be stable while resp_valid is high.
REQ-019 SHALL raise resp_valid exactly 129*DIV+1 cycles after the accepting edge and hold it until resp_ready is sampled high.
REQ-020 SHALL support simultaneous resp handshake and new req_valid: the new request is accepted no earlier than the IDLE gap of REQ-012 allows.
REQ-021 SHALL use a clock-cycle counter of 8 bits and an sck-period counter of 7 bits; neither SHALL wrap within a transaction.

Reset
REQ-022 On reset SHALL enter IDLE with sck=0, ss=1, mosi=0, req_ready=0, resp_valid=0, resp_data=0, and the ss-high gap counter cleared.
REQ-023 Reset asserted mid-transaction SHALL abort it: ss=1 and sck=0 the next cycle, no response ever produced for it.
REQ-024 req_ready SHALL first assert 2*DIV cycles after reset deasserts.

Structure
REQ-025 SHALL take from shared package spi_flash_pkg: state enum, command constant 8'h03, CMD_ADDR_BITS=32, DATA_BITS=32.
REQ-026 SHALL instantiate one sub-module spi_sck_gen (divider producing sck plus one-cycle rise/fall strobes, enabled only in SHIFT).

Verification
REQ-027 DIV=1, flash bytes 78 56 34 12 at 0x000004, req_addr=0x000007 -> mosi 0x03,0x00,0x00,0x04; resp_data=0x12345678; resp_valid at acceptance+130.
REQ-028 DIV=3, same read -> each sck high 3 / low 3 cycles, 64 periods, resp_valid at acceptance+388.
REQ-029 resp_ready held low 10 cycles -> resp_valid and resp_data stable, req_ready=0, ss=1, sck=0.
REQ-030 reset pulse at 20th sck rising edge -> next cycle ss=1, sck=0; no resp_valid; next read returns correct data.
REQ-031 DIV=2, back-to-back reads 0x0 and 0x100 with req_valid held -> ss high ≥4 cycles between, both responses correct, in order.
